// File: rtl/pio_pwm_pkg.sv
// Shared defaults and helpers for the PIO-driven LED PWM block.
package pio_pwm_pkg;

    localparam int DEF_CHANNELS     = 8;
    localparam int DEF_DUTY_W       = 8;
    localparam int DEF_PRESCALE     = 195;
    localparam int DEF_FADE_PERIODS = 4;

    // Working width of step_toward; callers zero-extend into it and truncate back.
    localparam int STEP_W = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One fade step: move cur by one toward tgt, never overshooting or wrapping.
    function automatic logic [STEP_W-1:0] step_toward(input logic [STEP_W-1:0] cur,
                                                      input logic [STEP_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + STEP_W'(1);
        end else if (cur > tgt) begin
            return cur - STEP_W'(1);
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/pio_led_pwm_if.sv
// Bundle between the PIO register side and the LED PWM block.
interface pio_led_pwm_if #(
    parameter int CHANNELS = pio_pwm_pkg::DEF_CHANNELS,
    parameter int DUTY_W   = pio_pwm_pkg::DEF_DUTY_W
);

    logic [CHANNELS*DUTY_W-1:0] pio_in;       // packed duty fields, channel i at [i*DUTY_W +: DUTY_W]
    logic                       fade_en;      // 1 = ramp toward target, 0 = snap
    logic [CHANNELS-1:0]        pwm_out;      // registered PWM outputs
    logic                       period_start; // one-cycle pulse when a PWM period begins
    logic                       busy;         // some channel still differs from its target

    // PIO / controller side.
    modport master (
        output pio_in, fade_en,
        input  pwm_out, period_start, busy
    );

    // PWM block side.
    modport slave (
        input  pio_in, fade_en,
        output pwm_out, period_start, busy
    );

endinterface

// File: rtl/pio_led_pwm_channel.sv
// One PWM channel: target/current duty registers and the registered compare output.
module pwm_channel
    import pio_pwm_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] i_cnt,       // shared period counter
    input  logic              i_boundary,  // last tick of the period
    input  logic              i_fade_en,
    input  logic              i_fade_step, // boundary on which faders move one step
    input  logic [DUTY_W-1:0] i_duty,      // this channel's field of pio_in
    output logic              o_pwm,
    output logic              o_mismatch
);

    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_current;
    logic              r_pwm;
    logic [DUTY_W-1:0] w_stepped;

    // Fade step is taken toward the freshly sampled field, not the old target.
    assign w_stepped = DUTY_W'(step_toward(STEP_W'(r_current), STEP_W'(i_duty)));

    // Duty registers load only on period boundaries so a period is never cut short.
    always_ff @(posedge clk) begin
        // NOTE: target/current are plain flops, not a RAM, so they are reset like any other state.
        if (reset) begin
            r_target  <= '0;
            r_current <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm <= (i_cnt < r_current);
            if (i_boundary) begin
                r_target <= i_duty;
                if (!i_fade_en) begin
                    r_current <= i_duty;
                end else if (i_fade_step) begin
                    r_current <= w_stepped;
                end
            end
        end
    end

    assign o_pwm      = r_pwm;
    assign o_mismatch = (r_current != r_target);

endmodule

// File: rtl/pio_led_pwm.sv
// LED PWM bank driven by the 64-bit PIO register: shared timebase plus one channel per field.
module pio_led_pwm
    import pio_pwm_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int FADE_PERIODS = DEF_FADE_PERIODS
) (
    input  logic         clk,
    input  logic         reset,
    pio_led_pwm_if.slave pio
);

    localparam int PSC_W = cnt_w(PRESCALE);
    localparam int FC_W  = cnt_w(FADE_PERIODS);

    logic [PSC_W-1:0]    r_psc;
    logic [DUTY_W-1:0]   r_cnt;
    logic [FC_W-1:0]     r_fcnt;
    logic                r_period_start;

    logic                w_tick;
    logic                w_boundary;
    logic                w_fade_step;
    logic [CHANNELS-1:0] w_pwm;
    logic [CHANNELS-1:0] w_mismatch;

    assign w_tick      = (r_psc == PSC_W'(PRESCALE - 1));
    assign w_boundary  = w_tick && (r_cnt == '1);
    assign w_fade_step = w_boundary && pio.fade_en && (r_fcnt == FC_W'(FADE_PERIODS - 1));

    // Prescaler: divides clk down to the PWM tick rate.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_psc <= '0;
        end else if (w_tick) begin
            r_psc <= '0;
        end else begin
            r_psc <= r_psc + PSC_W'(1);
        end
    end

    // Period counter: free-running over the full duty range, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + DUTY_W'(1);
        end
    end

    // Fade divider: counts boundaries between fade steps, parked at 0 while snapping.
    always_ff @(posedge clk) begin
        if (reset || !pio.fade_en) begin
            r_fcnt <= '0;
        end else if (w_boundary) begin
            if (r_fcnt == FC_W'(FADE_PERIODS - 1)) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FC_W'(1);
            end
        end
    end

    // Period start marker: high in the first cycle with cnt == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_cnt       (r_cnt),
            .i_boundary  (w_boundary),
            .i_fade_en   (pio.fade_en),
            .i_fade_step (w_fade_step),
            .i_duty      (pio.pio_in[g*DUTY_W +: DUTY_W]),
            .o_pwm       (w_pwm[g]),
            .o_mismatch  (w_mismatch[g])
        );
    end

    assign pio.pwm_out      = w_pwm;
    assign pio.period_start = r_period_start;
    assign pio.busy         = |w_mismatch;

endmodule

// File: tb/tb_pio_led_pwm.sv
// Directed bench for pio_led_pwm with PRESCALE=1, DUTY_W=8, CHANNELS=8, FADE_PERIODS=4.
module tb_pio_led_pwm;

    localparam int CHANNELS     = 8;
    localparam int DUTY_W       = 8;
    localparam int PRESCALE     = 1;
    localparam int FADE_PERIODS = 4;
    localparam int PERIOD       = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    pio_led_pwm_if #(.CHANNELS(CHANNELS), .DUTY_W(DUTY_W)) u_if ();

    pio_led_pwm #(
        .CHANNELS     (CHANNELS),
        .DUTY_W       (DUTY_W),
        .PRESCALE     (PRESCALE),
        .FADE_PERIODS (FADE_PERIODS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pio   (u_if)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int ch, input logic [DUTY_W-1:0] d);
        u_if.pio_in[ch*DUTY_W +: DUTY_W] = d;
    endtask

    // Wait (bounded) for the next period_start pulse.
    task automatic wait_ps(input string name);
        bit got = 1'b0;
        for (int k = 0; k < PERIOD + 8; k++) begin
            step();
            if (u_if.period_start) begin
                got = 1'b1;
                break;
            end
        end
        n_total++;
        if (got !== 1'b1) $display("FAIL %s_wait_ps: period_start got %0b expected 1", name, got);
        else n_pass++;
    endtask

    // Starting in a period_start cycle, run one full period and profile channel ch.
    // Ends in the following period_start cycle.
    task automatic measure(input string name, input int ch, output int highs,
                           output int first_high, output int first_low, output int others);
        logic [CHANNELS-1:0] mask;
        int ps_pos;
        mask       = ~(CHANNELS'(1) << ch);
        highs      = 0;
        first_high = 0;
        first_low  = 0;
        others     = 0;
        ps_pos     = 0;
        for (int j = 1; j <= PERIOD; j++) begin
            step();
            if (u_if.pwm_out[ch]) begin
                highs++;
                if (first_high == 0) first_high = j;
            end else if (first_low == 0) begin
                first_low = j;
            end
            if ((u_if.pwm_out & mask) != '0) others++;
            if (u_if.period_start && ps_pos == 0) ps_pos = j;
        end
        n_total++;
        if (ps_pos !== PERIOD) $display("FAIL %s_period_align: period_start at %0d expected %0d", name, ps_pos, PERIOD);
        else n_pass++;
    endtask

    task automatic test_reset();
        int n_ps = 0, first_ps = 0, second_ps = 0, bad_pwm = 0, bad_busy = 0;
        reset        = 1'b1;
        u_if.pio_in  = '0;
        u_if.fade_en = 1'b0;
        repeat (3) step();
        n_total++;
        if (u_if.pwm_out !== '0) $display("FAIL rst_pwm: got %h expected 00", u_if.pwm_out);
        else n_pass++;
        n_total++;
        if (u_if.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", u_if.busy);
        else n_pass++;
        n_total++;
        if (u_if.period_start !== 1'b0) $display("FAIL rst_ps: got %b expected 0", u_if.period_start);
        else n_pass++;
        reset = 1'b0;
        for (int k = 1; k <= 2 * PERIOD + 8; k++) begin
            step();
            if (u_if.period_start) begin
                n_ps++;
                if (first_ps == 0) first_ps = k;
                else if (second_ps == 0) second_ps = k;
            end
            if (u_if.pwm_out !== '0) bad_pwm++;
            if (u_if.busy !== 1'b0) bad_busy++;
        end
        n_total++;
        if (first_ps !== 256) $display("FAIL rst_first_ps: got %0d expected 256", first_ps);
        else n_pass++;
        n_total++;
        if (second_ps !== 512) $display("FAIL rst_second_ps: got %0d expected 512", second_ps);
        else n_pass++;
        n_total++;
        if (n_ps !== 2) $display("FAIL rst_ps_count: got %0d expected 2", n_ps);
        else n_pass++;
        n_total++;
        if (bad_pwm !== 0) $display("FAIL rst_pwm_idle: %0d cycles high, expected 0", bad_pwm);
        else n_pass++;
        n_total++;
        if (bad_busy !== 0) $display("FAIL rst_busy_idle: %0d cycles busy, expected 0", bad_busy);
        else n_pass++;
    endtask

    task automatic test_snap();
        int h, fh, fl, oth;
        u_if.fade_en = 1'b0;
        set_duty(0, 8'h40);
        wait_ps("snap");
        for (int p = 0; p < 2; p++) begin
            measure("snap", 0, h, fh, fl, oth);
            n_total++;
            if (h !== 64) $display("FAIL snap_highs[%0d]: got %0d expected 64", p, h);
            else n_pass++;
            n_total++;
            if (fh !== 1) $display("FAIL snap_first_high[%0d]: got %0d expected 1", p, fh);
            else n_pass++;
            n_total++;
            if (oth !== 0) $display("FAIL snap_others[%0d]: got %0d expected 0", p, oth);
            else n_pass++;
        end
        n_total++;
        if (u_if.busy !== 1'b0) $display("FAIL snap_busy: got %b expected 0", u_if.busy);
        else n_pass++;
    endtask

    task automatic test_extremes();
        int h, fh, fl, oth;
        u_if.pio_in = '0;
        set_duty(7, 8'hFF);
        wait_ps("ext_ff");
        measure("ext_ff", 7, h, fh, fl, oth);
        n_total++;
        if (h !== 255) $display("FAIL ext_ff_highs: got %0d expected 255", h);
        else n_pass++;
        n_total++;
        if (fl !== 256) $display("FAIL ext_ff_low_slot: got %0d expected 256", fl);
        else n_pass++;
        n_total++;
        if (oth !== 0) $display("FAIL ext_ff_others: got %0d expected 0", oth);
        else n_pass++;
        set_duty(7, 8'h00);
        wait_ps("ext_00");
        measure("ext_00", 7, h, fh, fl, oth);
        n_total++;
        if (h !== 0) $display("FAIL ext_00_highs: got %0d expected 0", h);
        else n_pass++;
    endtask

    task automatic test_mid_change();
        int h = 0, fh, fl, oth;
        u_if.pio_in = '0;
        set_duty(0, 8'h80);
        wait_ps("mid");
        for (int j = 1; j <= PERIOD; j++) begin
            step();
            if (u_if.pwm_out[0]) h++;
            if (j == 100) set_duty(0, 8'h10);
        end
        n_total++;
        if (h !== 128) $display("FAIL mid_current_period: got %0d expected 128", h);
        else n_pass++;
        n_total++;
        if (u_if.period_start !== 1'b1) $display("FAIL mid_ps: got %b expected 1", u_if.period_start);
        else n_pass++;
        for (int p = 0; p < 2; p++) begin
            measure("mid", 0, h, fh, fl, oth);
            n_total++;
            if (h !== 16) $display("FAIL mid_next_period[%0d]: got %0d expected 16", p, h);
            else n_pass++;
        end
    endtask

    task automatic test_fade();
        int h, fh, fl, oth, exp_h;
        logic exp_busy;
        u_if.fade_en = 1'b0;
        u_if.pio_in  = '0;
        wait_ps("fade_clear");
        u_if.fade_en = 1'b1;
        set_duty(2, 8'd3);
        n_total++;
        if (u_if.busy !== 1'b0) $display("FAIL fade_busy_before: got %b expected 0", u_if.busy);
        else n_pass++;
        // Ramp up: period k-1 runs at (k-1)/4, busy after boundary k while k < 12.
        for (int k = 1; k <= 12; k++) begin
            measure("fade_up", 2, h, fh, fl, oth);
            exp_h    = (k - 1) / FADE_PERIODS;
            exp_busy = (k < 12);
            n_total++;
            if (h !== exp_h) $display("FAIL fade_up_duty[%0d]: got %0d expected %0d", k, h, exp_h);
            else n_pass++;
            n_total++;
            if (u_if.busy !== exp_busy) $display("FAIL fade_up_busy[%0d]: got %b expected %b", k, u_if.busy, exp_busy);
            else n_pass++;
        end
        set_duty(2, 8'd0);
        // Ramp down from 3 over the same number of boundaries.
        for (int m = 1; m <= 12; m++) begin
            measure("fade_dn", 2, h, fh, fl, oth);
            exp_h    = 3 - (m - 1) / FADE_PERIODS;
            exp_busy = (m < 12);
            n_total++;
            if (h !== exp_h) $display("FAIL fade_dn_duty[%0d]: got %0d expected %0d", m, h, exp_h);
            else n_pass++;
            n_total++;
            if (u_if.busy !== exp_busy) $display("FAIL fade_dn_busy[%0d]: got %b expected %b", m, u_if.busy, exp_busy);
            else n_pass++;
        end
        measure("fade_end", 2, h, fh, fl, oth);
        n_total++;
        if (h !== 0) $display("FAIL fade_end_duty: got %0d expected 0", h);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int h = 0, first_ps = 0, fh, fl, oth;
        u_if.fade_en = 1'b0;
        u_if.pio_in  = '0;
        set_duty(0, 8'h80);
        wait_ps("rmid");
        repeat (10) step();
        n_total++;
        if (u_if.pwm_out[0] !== 1'b1) $display("FAIL rmid_high_before: got %b expected 1", u_if.pwm_out[0]);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if (u_if.pwm_out !== '0) $display("FAIL rmid_pwm_cleared: got %h expected 00", u_if.pwm_out);
        else n_pass++;
        n_total++;
        if (u_if.period_start !== 1'b0) $display("FAIL rmid_ps: got %b expected 0", u_if.period_start);
        else n_pass++;
        for (int k = 1; k <= PERIOD; k++) begin
            step();
            if (u_if.pwm_out[0]) h++;
            if (u_if.period_start && first_ps == 0) first_ps = k;
        end
        n_total++;
        if (h !== 0) $display("FAIL rmid_duty_zero: got %0d highs expected 0", h);
        else n_pass++;
        n_total++;
        if (first_ps !== 256) $display("FAIL rmid_cnt_restart: first period_start at %0d expected 256", first_ps);
        else n_pass++;
        measure("rmid", 0, h, fh, fl, oth);
        n_total++;
        if (h !== 128) $display("FAIL rmid_resampled: got %0d expected 128", h);
        else n_pass++;
        n_total++;
        if (fh !== 1) $display("FAIL rmid_first_high: got %0d expected 1", fh);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_snap();
        test_extremes();
        test_mid_change();
        test_fade();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case the DUT stalls somewhere the bounded waits do not cover.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/pio_led_pwm.md
# pio_led_pwm

Downstream consumer of the 64-bit Avalon PIO output register. It turns the PIO word into per-channel LED brightness by interpreting it as `CHANNELS` packed duty-cycle fields. Each field drives a glitch-free PWM output; new duty values take effect only at PWM period boundaries. An optional fade mode ramps each channel's brightness toward the new value one step at a time.

## Interface
Parameters:
- `CHANNELS`, 8: number of PWM outputs.
- `DUTY_W`, 8: duty field width; PWM period is 2^DUTY_W ticks.
- `PRESCALE`, 195: clk cycles per PWM tick, ≥1. 50 MHz / 195 / 256 ≈ 1 kHz.
- `FADE_PERIODS`, 4: PWM periods per fade step, ≥1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `pio_in`, in, CHANNELS*DUTY_W: packed duties; channel i = bits [i*DUTY_W +: DUTY_W]. Driven directly from the PIO register output.
- `fade_en`, in, 1: 1 = ramp toward the target; 0 = snap to the target.
- `pwm_out`, out, CHANNELS: registered PWM outputs.
- `period_start`, out, 1: one-cycle pulse at the start of each PWM period.
- `busy`, out, 1: high while any channel's current duty ≠ target.

## Operation
- **Prescaler** `psc` counts 0..PRESCALE-1.
  - `tick` is asserted when `psc == PRESCALE-1`; `psc` then wraps to 0.
  - With PRESCALE=1, `tick` is asserted every cycle.
- **Period counter** `cnt` (DUTY_W bits) increments on `tick`, wrapping from 2^DUTY_W-1 to 0.
- **Boundary** = `tick` while `cnt == 2^DUTY_W-1`. On a boundary:
  - `target[i] <= pio_in` field i. `pio_in` is sampled only here; changes mid-period are ignored.
  - If `fade_en == 0`:
    - `current[i] <=` the new field.
    - `fcnt <= 0`.
  - If `fade_en == 1`:
    - If `fcnt == FADE_PERIODS-1`: `fcnt <= 0`, and each `current[i]` steps by ±1 toward the newly sampled field. No step when it is already equal.
    - Otherwise `fcnt <= fcnt + 1`.
- While `fade_en == 0`, `fcnt` is held at 0 every cycle.
- **Duty output:** every cycle, `pwm_out[i] <= (cnt < current[i])`.
  - Duty 0 gives constant low.
  - Duty 2^DUTY_W-1 gives high for 255 of 256 ticks. 100% duty is not representable.
- **Comparisons:** unsigned, DUTY_W-bit. Fade stepping never wraps.
- **busy** is combinational: OR over i of `(current[i] != target[i])`.
- **Fade toggled:**
  - `fade_en` dropping mid-fade makes the channel snap at the next boundary.
  - `fade_en` rising starts ramping from the present `current` value.

## Timing
- **Reset values:** `psc`, `cnt`, `fcnt`, `target`, `current` = 0; `pwm_out` = 0; `period_start` = 0; `busy` = 0.
- **Reset mid-operation:** all state returns to the reset values on the next edge, and `pwm_out` is 0 the following cycle. Reset has priority over `tick` and boundary.
- **Boundary edge:**
  - `cnt` becomes 0 and `current` updates on the same edge.
  - `period_start` is registered and is high during the cycle in which `cnt == 0` first holds.
- **Output latency:** `pwm_out` reflects a new duty starting one clk after `period_start`.
  - Rising edge of `pwm_out[i]` at `period_start` + 1 cycle, for `current[i] > 0`.
  - High for `current[i] * PRESCALE` clk per period.
- **Update latency:** from a `pio_in` change to its effect on `pwm_out`, at most one PWM period + 1 clk when `fade_en == 0`.
- **Fade duration:** a ramp of Δ takes Δ·FADE_PERIODS boundaries.

## Structure
- **Package `pio_pwm_pkg`:**
  - Localparam defaults for DUTY_W and CHANNELS.
  - Function `step_toward(cur, tgt)` returning cur±1 or cur.
- **Sub-module `pwm_channel`:** one per channel, via generate.
  - Holds `target`, `current` and the output compare register.
  - Inputs: `cnt`, `boundary`, `fade_en`, `fade_step`, its duty field.
  - Outputs: `pwm_out` bit and `mismatch`.
- **Top level:** prescaler, `cnt`, `fcnt`, `period_start`, and the `busy` OR-reduction.

## Test plan
All scenarios use PRESCALE=1, DUTY_W=8, CHANNELS=8, FADE_PERIODS=4.
1. Reset, with `pio_in = 0` after release:
   - `pwm_out = 0`, `busy = 0` throughout.
   - `period_start` pulses every 256 cycles; first pulse 256 cycles after reset release.
2. Snap, `fade_en = 0`, ch0 = 0x40:
   - After the next `period_start`, `pwm_out[0]` goes high 1 cycle later.
   - It stays high exactly 64 cycles per 256-cycle period. Other channels stay 0.
3. Extremes:
   - ch7 = 0xFF gives high for 255 of every 256 cycles, low only at the `cnt == 255` compare slot.
   - ch7 = 0x00 gives never high.
4. Mid-period change: ch0 at 0x80, `pio_in` changed to 0x10 at `cnt == 100`.
   - The current period still gives a 128-cycle high.
   - Subsequent periods give 16-cycle highs.
5. Fade, `fade_en = 1`, ch2 ramped 0 → 3:
   - `current` becomes 1, 2, 3 at boundaries 4, 8, 12.
   - `busy` stays high until boundary 12, then drops.
   - Ramp 3 → 0 takes the same time.
6. Reset mid-operation: reset asserted for 1 cycle while `pwm_out[0]` is high with duty 0x80.
   - `pwm_out` is 0 on the next cycle.
   - `cnt` restarts from 0; duty stays 0 until `pio_in` is resampled at the next boundary.
